serial_mode_sequencer: RTL

SERIAL_MODE_SEQUENCER -- requirements
Module: serial_mode_sequencer

---
 rtl/serial_mode_sequencer_if.sv | 33 +++
 rtl/serial_mode_sequencer.sv | 123 ++++++++++++
 2 files changed

// File: rtl/serial_mode_sequencer_if.sv
// rtl/serial_mode_sequencer_if.sv - batch control, engine handshake and result write port of the sequencer
interface serial_mode_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4
);
    logic              start_i;
    logic [CNT_W-1:0]  job_count_i;
    logic [ADDR_W-1:0] base_start_i;
    logic [ADDR_W-1:0] stride_i;
    logic              en_o;
    logic [ADDR_W-1:0] feature_baseaddr_o;
    logic              is_done_i;
    logic [DATA_W-1:0] result_i;
    logic              wr_en_o;
    logic [CNT_W-1:0]  wr_addr_o;
    logic [DATA_W-1:0] wr_data_o;
    logic              busy_o;
    logic              all_done_o;
    logic              error_o;

    modport master (
        input  start_i, job_count_i, base_start_i, stride_i, is_done_i, result_i,
        output en_o, feature_baseaddr_o, wr_en_o, wr_addr_o, wr_data_o,
               busy_o, all_done_o, error_o
    );

    modport slave (
        output start_i, job_count_i, base_start_i, stride_i, is_done_i, result_i,
        input  en_o, feature_baseaddr_o, wr_en_o, wr_addr_o, wr_data_o,
               busy_o, all_done_o, error_o
    );
endinterface

// File: rtl/serial_mode_sequencer.sv
// rtl/serial_mode_sequencer.sv - runs a batch of engine jobs at strided addresses and writes each result
module serial_mode_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int CNT_W   = 4,
    parameter int TIMEOUT = 255
) (
    input logic                  clk,
    input logic                  rst,
    serial_mode_sequencer_if.master bus
);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_WRITE,
        S_RELEASE,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [ADDR_W-1:0] stride_q, stride_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic [WD_W-1:0]   wdog_q, wdog_d;
    logic              err_q, err_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            stride_q <= '0;
            addr_q   <= '0;
            res_q    <= '0;
            wdog_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            stride_q <= stride_d;
            addr_q   <= addr_d;
            res_q    <= res_d;
            wdog_q   <= wdog_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        stride_d = stride_q;
        addr_d   = addr_q;
        res_d    = res_q;
        wdog_d   = wdog_q;
        err_d    = err_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start_i) begin
                    cnt_d    = bus.job_count_i;
                    stride_d = bus.stride_i;
                    addr_d   = bus.base_start_i;
                    idx_d    = '0;
                    err_d    = 1'b0;
                    state_d  = (bus.job_count_i == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                wdog_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A done arriving on the expiry cycle still counts as completion.
                if (bus.is_done_i) begin
                    res_d   = bus.result_i;
                    state_d = S_WRITE;
                end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
            end
            S_WRITE: begin
                state_d = S_RELEASE;
            end
            S_RELEASE: begin
                // The engine must drop done before the next job is issued.
                if (!bus.is_done_i) begin
                    if (idx_q == cnt_q - CNT_W'(1)) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + CNT_W'(1);
                        addr_d  = addr_q + stride_q;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.en_o               = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_WRITE);
    assign bus.feature_baseaddr_o = addr_q;
    assign bus.wr_en_o            = (state_q == S_WRITE);
    assign bus.wr_addr_o          = idx_q;
    assign bus.wr_data_o          = res_q;
    assign bus.busy_o             = (state_q != S_IDLE);
    assign bus.all_done_o         = (state_q == S_DONE);
    assign bus.error_o            = err_q;
endmodule
